// File: rtl/usr_shift_sequencer_if.sv
// Handshake and shift-register drive bundle for usr_shift_sequencer.
// master = upstream word source, slave = the sequencer itself.
interface usr_shift_sequencer_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH + 2);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic             flush;
    logic [1:0]       sel;
    logic [WIDTH-1:0] pdi;
    logic             sldi;
    logic             srdi;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] shift_cnt;

    modport master (
        output in_valid, in_data, in_dir, flush,
        input  in_ready, sel, pdi, sldi, srdi, busy, done, shift_cnt
    );

    modport slave (
        input  in_valid, in_data, in_dir, flush,
        output in_ready, sel, pdi, sldi, srdi, busy, done, shift_cnt
    );
endinterface

// File: rtl/usr_shift_sequencer.sv
// Self-timed load/shift/gap sequencer driving a universal shift register.
// Define USR_SEQ_PARITY_EN to append an even-parity bit as an extra shift cycle.
module usr_shift_sequencer #(
    parameter int   WIDTH      = 4,
    parameter int   GAP_CYCLES = 0,
    parameter logic FILL       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    usr_shift_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef USR_SEQ_PARITY_EN
    localparam int NSHIFT = WIDTH + 1;
`else
    localparam int NSHIFT = WIDTH;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_RIGHT = 2'd1;
    localparam logic [1:0] SEL_LEFT  = 2'd2;
    localparam logic [1:0] SEL_LOAD  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(NSHIFT - 1);
    localparam logic [3:0]       GAP_LAST   = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

`ifdef USR_SEQ_PARITY_EN
    localparam logic [CNT_W-1:0] PARITY_SLOT = CNT_W'(WIDTH);

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic [1:0]       sel_q, sel_d;
    logic             sldi_q, sldi_d;
    logic             srdi_q, srdi_d;
    logic             done_q, done_d;
    logic             serial_bit;

    // Next-state, word capture and counters; flush overrides everything.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state_d = ST_LOAD;
                        word_d  = bus.in_data;
                        dir_d   = bus.in_dir;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_ZERO;
                end
                ST_SHIFT: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_SHIFT) begin
                        done_d = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            gap_d   = GAP_LAST;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Register-bound drive derived from the state being entered, so sel lines up with it.
    always_comb begin
        sel_d  = SEL_HOLD;
        sldi_d = 1'b0;
        srdi_d = 1'b0;
`ifdef USR_SEQ_PARITY_EN
        if (cnt_d == PARITY_SLOT) begin
            serial_bit = even_parity(word_d);
        end else begin
            serial_bit = FILL;
        end
`else
        serial_bit = FILL;
`endif
        case (state_d)
            ST_LOAD: begin
                sel_d = SEL_LOAD;
            end
            ST_SHIFT: begin
                if (dir_d) begin
                    sel_d  = SEL_LEFT;
                    sldi_d = serial_bit;
                end else begin
                    sel_d  = SEL_RIGHT;
                    srdi_d = serial_bit;
                end
            end
            ST_IDLE, ST_GAP: begin
                sel_d = SEL_HOLD;
            end
            default: begin
                sel_d = SEL_HOLD;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= {WIDTH{1'b0}};
            dir_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
            gap_q   <= 4'd0;
            sel_q   <= SEL_HOLD;
            sldi_q  <= 1'b0;
            srdi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            sldi_q  <= sldi_d;
            srdi_q  <= srdi_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sel       = sel_q;
    assign bus.pdi       = word_q;
    assign bus.sldi      = sldi_q;
    assign bus.srdi      = srdi_q;
    assign bus.done      = done_q;
    assign bus.shift_cnt = cnt_q;
endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Scoreboard bench for usr_shift_sequencer: two instances (no gap / FILL=1, gap of 2 / FILL=0).
// Honours USR_SEQ_PARITY_EN the same way the design does.
module tb_usr_shift_sequencer;
    localparam int W = 4;
`ifdef USR_SEQ_PARITY_EN
    localparam int NSHIFT = W + 1;
`else
    localparam int NSHIFT = W;
`endif
    localparam int   GAP_P  [2] = '{0, 2};
    localparam logic FILL_P [2] = '{1'b1, 1'b0};

    typedef struct {
        logic [1:0] sel;
        logic [3:0] pdi;
        logic       chk_pdi;
        logic       sldi;
        logic       srdi;
        logic       chk_ser;
        logic       done;
        logic       busy;
        logic       ready;
        int         cnt;
        logic       chk_cnt;
    } rec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_dir;
    logic       flush;
    int         cyc;
    int         checks;
    int         errors;
    int         next_ok [2];
    rec_t       sbq [2][$];

    logic [1:0] o_sel   [2];
    logic [3:0] o_pdi   [2];
    logic       o_sldi  [2];
    logic       o_srdi  [2];
    logic       o_busy  [2];
    logic       o_done  [2];
    logic       o_ready [2];
    logic [2:0] o_cnt   [2];

    usr_shift_sequencer_if #(.WIDTH(W)) bus0 ();
    usr_shift_sequencer_if #(.WIDTH(W)) bus1 ();

    usr_shift_sequencer #(.WIDTH(W), .GAP_CYCLES(0), .FILL(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );
    usr_shift_sequencer #(.WIDTH(W), .GAP_CYCLES(2), .FILL(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus0.in_valid = in_valid;
    assign bus0.in_data  = in_data;
    assign bus0.in_dir   = in_dir;
    assign bus0.flush    = flush;
    assign bus1.in_valid = in_valid;
    assign bus1.in_data  = in_data;
    assign bus1.in_dir   = in_dir;
    assign bus1.flush    = flush;

    assign o_sel[0] = bus0.sel;        assign o_sel[1] = bus1.sel;
    assign o_pdi[0] = bus0.pdi;        assign o_pdi[1] = bus1.pdi;
    assign o_sldi[0] = bus0.sldi;      assign o_sldi[1] = bus1.sldi;
    assign o_srdi[0] = bus0.srdi;      assign o_srdi[1] = bus1.srdi;
    assign o_busy[0] = bus0.busy;      assign o_busy[1] = bus1.busy;
    assign o_done[0] = bus0.done;      assign o_done[1] = bus1.done;
    assign o_ready[0] = bus0.in_ready; assign o_ready[1] = bus1.in_ready;
    assign o_cnt[0] = bus0.shift_cnt;  assign o_cnt[1] = bus1.shift_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, inst, act, exp_v, $time);
        end
    endtask

    // Expected per-cycle trace of one accepted word: load, shifts, done, remaining gap cycles.
    task automatic push_word(input int i, input logic [3:0] w, input logic dir);
        rec_t r;
        logic b;
        r = '{sel: 2'd3, pdi: w, chk_pdi: 1'b1, sldi: 1'b0, srdi: 1'b0, chk_ser: 1'b0,
              done: 1'b0, busy: 1'b1, ready: 1'b0, cnt: 0, chk_cnt: 1'b0};
        sbq[i].push_back(r);
        for (int s = 0; s < NSHIFT; s++) begin
            b = (s == W) ? 1'(($countones(w) % 2) == 1) : FILL_P[i];
            r.sel = dir ? 2'd2 : 2'd1;
            r.sldi = dir ? b : 1'b0;
            r.srdi = dir ? 1'b0 : b;
            r.chk_ser = 1'b1;
            r.cnt = s;
            r.chk_cnt = 1'b1;
            sbq[i].push_back(r);
        end
        r = '{sel: 2'd0, pdi: w, chk_pdi: 1'b0, sldi: 1'b0, srdi: 1'b0, chk_ser: 1'b0,
              done: 1'b1, busy: (GAP_P[i] > 0), ready: (GAP_P[i] == 0), cnt: NSHIFT, chk_cnt: 1'b1};
        sbq[i].push_back(r);
        for (int g = 1; g < GAP_P[i]; g++) begin
            r.done = 1'b0;
            r.busy = 1'b1;
            r.ready = 1'b0;
            sbq[i].push_back(r);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic dir, input logic f);
        rec_t r;
        int e;
        @(negedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        in_dir   = dir;
        flush    = f;
        e = cyc + 1;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (f) begin
                    sbq[i].delete();
                    r = '{sel: 2'd0, pdi: 4'd0, chk_pdi: 1'b0, sldi: 1'b0, srdi: 1'b0, chk_ser: 1'b1,
                          done: 1'b0, busy: 1'b0, ready: 1'b1, cnt: 0, chk_cnt: 1'b0};
                    sbq[i].push_back(r);
                    next_ok[i] = e + 1;
                end else if (v && (e >= next_ok[i])) begin
                    push_word(i, d, dir);
                    next_ok[i] = e + NSHIFT + GAP_P[i] + 2;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // Monitor: reset values while rst, scoreboard records while busy, idle outputs otherwise.
    always @(negedge clk) begin : monitor
        rec_t r;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                chk("rst_sel", i, 32'(o_sel[i]), 32'd0);
                chk("rst_pdi", i, 32'(o_pdi[i]), 32'd0);
                chk("rst_sldi", i, 32'(o_sldi[i]), 32'd0);
                chk("rst_srdi", i, 32'(o_srdi[i]), 32'd0);
                chk("rst_done", i, 32'(o_done[i]), 32'd0);
                chk("rst_cnt", i, 32'(o_cnt[i]), 32'd0);
                chk("rst_busy", i, 32'(o_busy[i]), 32'd0);
                chk("rst_ready", i, 32'(o_ready[i]), 32'd1);
            end else if (sbq[i].size() > 0) begin
                r = sbq[i].pop_front();
                chk("sel", i, 32'(o_sel[i]), 32'(r.sel));
                chk("done", i, 32'(o_done[i]), 32'(r.done));
                chk("busy", i, 32'(o_busy[i]), 32'(r.busy));
                chk("in_ready", i, 32'(o_ready[i]), 32'(r.ready));
                if (r.chk_pdi) chk("pdi", i, 32'(o_pdi[i]), 32'(r.pdi));
                if (r.chk_ser) begin
                    chk("sldi", i, 32'(o_sldi[i]), 32'(r.sldi));
                    chk("srdi", i, 32'(o_srdi[i]), 32'(r.srdi));
                end
                if (r.chk_cnt) chk("shift_cnt", i, 32'(o_cnt[i]), 32'(r.cnt));
            end else begin
                chk("idle_sel", i, 32'(o_sel[i]), 32'd0);
                chk("idle_done", i, 32'(o_done[i]), 32'd0);
                chk("idle_busy", i, 32'(o_busy[i]), 32'd0);
                chk("idle_ready", i, 32'(o_ready[i]), 32'd1);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        in_dir   = 1'b0;
        flush    = 1'b0;
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        next_ok[0] = 0;
        next_ok[1] = 0;
        idle(3);
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Right shift of 4'hA.
        drive(1'b1, 4'hA, 1'b0, 1'b0);
        idle(12);

        // Left shift of 4'h5 with valid held for two words.
        for (int k = 0; k < 9; k++) drive(1'b1, 4'h5, 1'b1, 1'b0);
        idle(14);

        // Flush during LOAD, then flush racing an accept in IDLE.
        drive(1'b1, 4'h9, 1'b1, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 4'hC, 1'b0, 1'b1);
        idle(4);

        // Parity-relevant words (odd and even population).
        drive(1'b1, 4'h7, 1'b0, 1'b0);
        idle(12);
        drive(1'b1, 4'h3, 1'b1, 1'b0);
        idle(12);

        // Asynchronous reset in the second shift cycle.
        drive(1'b1, 4'hA, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk("pre_rst_sel", i, 32'(o_sel[i]), 32'd1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_sel", i, 32'(o_sel[i]), 32'd0);
            chk("async_rst_busy", i, 32'(o_busy[i]), 32'd0);
            chk("async_rst_ready", i, 32'(o_ready[i]), 32'd1);
            chk("async_rst_done", i, 32'(o_done[i]), 32'd0);
            sbq[i].delete();
            next_ok[i] = 0;
        end
        idle(2);
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle(10);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom_range(0, 99) < 60), 4'($urandom), 1'($urandom),
                  1'($urandom_range(0, 99) < 3));
        end
        idle(16);
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usr_shift_sequencer.md
Name: usr_shift_sequencer

Overview:
- Control stage directly upstream of the team's 4-bit universal shift register.
- Accepts one parallel word per valid/ready handshake and drives the register's sel, pdi, sldi and srdi inputs:
  - one load cycle,
  - then WIDTH shift cycles in the requested direction,
  - then an optional idle gap.
- Turns the shift register into a self-timed parallel-to-serial engine, so no CPU or testbench has to toggle sel by hand.

Parameters:
- WIDTH, 4, data width of the downstream shift register (>=2).
- GAP_CYCLES, 0, hold cycles (sel=0) inserted after each word before accepting the next (0..15).
- FILL, 1'b0, bit driven on the active serial input during shift cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  sequencer can accept a word
- in_data  input  WIDTH  word to serialize
- in_dir  input  1  0 = right shift (sel=1), 1 = left shift (sel=2); sampled with in_data
- flush  input  1  synchronous abort, return to IDLE
- sel  output  2  to shift register: 0 hold, 1 right, 2 left, 3 parallel load
- pdi  output  WIDTH  to shift register parallel input
- sldi  output  1  to shift register serial-left input
- srdi  output  1  to shift register serial-right input
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse, word fully shifted
- shift_cnt  output  clog2(WIDTH+2)  shift cycles completed for the current word

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Outputs: all outputs are registered except in_ready and busy, which are decoded from the state register.
- Reset values: state=IDLE, sel=0, pdi=0, sldi=0, srdi=0, done=0, shift_cnt=0, busy=0, in_ready=1. Reset takes effect immediately and asynchronously, including mid-word. No done pulse is produced for an aborted word.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - in_ready=1, sel=0.
  - When in_valid=1, in_data and in_dir are captured at the clock edge and the next state is LOAD.
- LOAD (exactly 1 cycle):
  - sel=3, pdi=captured word.
  - Next state SHIFT, shift_cnt=0.
- SHIFT:
  - sel = in_dir ? 2 : 1.
  - Right shift: srdi=FILL, sldi=0. Left shift: sldi=FILL, srdi=0.
  - shift_cnt increments every cycle.
  - After WIDTH shift cycles (NSHIFT, see Optional Feature), the next state is GAP if GAP_CYCLES>0, otherwise IDLE.
  - pdi holds the captured word throughout.
- done: high for exactly one cycle, the first cycle after the last shift cycle, coincident with entry to GAP or IDLE.
- GAP:
  - sel=0 for GAP_CYCLES cycles, then IDLE.
  - shift_cnt holds its final value until the next LOAD.
- Timing:
  - Accept at edge k: sel=3 during cycle k+1, shift cycles k+2 .. k+1+NSHIFT, done in cycle k+2+NSHIFT.
  - Minimum accept-to-accept period is NSHIFT+GAP_CYCLES+2 cycles.
- Handshake:
  - A transfer occurs only when in_valid && in_ready at the edge.
  - in_ready=0 in LOAD, SHIFT and GAP. in_data is don't-care while in_ready=0.
- flush:
  - In any state, the next state is IDLE. sel, sldi and srdi are 0 from the next cycle. done is not asserted.
  - flush wins over a simultaneous accept in IDLE; the word is not taken.
- done and accept may not occur on the same edge: done is asserted on the cycle of entry to IDLE, and acceptance is possible from that cycle onward.
- sel encodes only the four states listed; there are no undefined sel values.

Optional Feature:
- Macro: USR_SEQ_PARITY_EN.
- Defined:
  - NSHIFT=WIDTH+1.
  - During shift cycles 0..WIDTH-1 the active serial input carries FILL.
  - During the extra final cycle it carries the even parity (XOR reduction) of the captured word.
  - shift_cnt reaches WIDTH+1 before done.
- Undefined: NSHIFT=WIDTH, with no parity cycle and no parity logic.

Test Plan:
- Reset mid-SHIFT:
  - Stimulus: accept 4'hA with in_dir=0, assert rst during the 2nd shift cycle.
  - Required response: sel=0, busy=0, in_ready=1 asynchronously, and no done pulse.
- Right-shift word:
  - Stimulus: in_data=4'hA, in_dir=0, GAP_CYCLES=0.
  - Required response: sel=3 with pdi=A for 1 cycle; sel=1 for 4 cycles with srdi=FILL; done=1 on cycle 6 after the accept edge; in_ready=1 on the same cycle.
- Left shift with gap:
  - Stimulus: in_data=4'h5, in_dir=1, GAP_CYCLES=2, in_valid held high for two words.
  - Required response: sel=2 for 4 cycles; sel=0 for 2 cycles; second accept exactly 8 cycles after the first.
- flush with accept:
  - Stimulus: flush during LOAD; then flush=1 together with in_valid=1 in IDLE.
  - Required response: return to IDLE with no done; the IDLE word is not accepted (sel stays 0).
- Parity option:
  - Stimulus: with USR_SEQ_PARITY_EN, send 4'h7.
  - Required response: 5 shift cycles; the 5th carries parity bit 1; shift_cnt=5 at done.
  - Repeat with 4'h3: parity bit 0.
